// File: rtl/gf_mul_seq.sv
// gf_mul_seq: sequential GF(2^M) multiplier using MSB-first Horner steps.
// Each BUSY cycle folds DIGIT bits of the multiplier, and an optional
// accumulate mode XORs in the previously delivered product.
module gf_mul_seq #(
  parameter int         M     = 8,
  parameter logic [M:0] POLY  = 9'h11D,
  parameter int         DIGIT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] in_a,
  input  logic [M-1:0] in_b,
  input  logic         in_acc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_prod,
  output logic         busy
);

  localparam int L  = M / DIGIT;
  localparam int CW = (L > 1) ? $clog2(L) : 1;

  generate
    if (M < 2 || M > 16 || DIGIT < 1 || DIGIT > M || (M % DIGIT) != 0 ||
        POLY[M] != 1'b1 || POLY[0] != 1'b1) begin : g_param_check
      $fatal(1, "gf_mul_seq: illegal M/DIGIT/POLY combination");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state, state_next;
  logic           ready_raw;
  logic           accept;
  logic           deliver;
  logic           last_step;
  logic [CW-1:0]  cnt;
  logic [M-1:0]   a_p0;
  logic [M-1:0]   b_p0;
  logic [M-1:0]   acc_p0;
  logic [M-1:0]   base_p0;
  logic [M-1:0]   last_prod;
  logic [M-1:0]   acc_step;

  // One Horner step: multiply by x, reduce modulo POLY, add a if the bit is set.
  function automatic logic [M-1:0] gf_step(input logic [M-1:0] acc,
                                           input logic [M-1:0] a,
                                           input logic         bit_b);
    logic [M:0] sh;
    sh = {acc, 1'b0};
    if (sh[M]) sh = sh ^ POLY;
    return sh[M-1:0] ^ (bit_b ? a : '0);
  endfunction

  // DIGIT consecutive Horner steps, most significant multiplier bit first.
  function automatic logic [M-1:0] digit_step(input logic [M-1:0]     acc,
                                              input logic [M-1:0]     a,
                                              input logic [DIGIT-1:0] bits);
    logic [M-1:0] r;
    r = acc;
    for (int i = DIGIT - 1; i >= 0; i--) r = gf_step(r, a, bits[i]);
    return r;
  endfunction

  assign acc_step  = digit_step(acc_p0, a_p0, b_p0[M-1 -: DIGIT]);
  assign last_step = (cnt == CW'(L - 1));
  assign out_valid = (state == DONE);
  assign busy      = (state == BUSY);
  assign in_ready  = ready_raw & rst_n;
  assign accept    = in_valid & in_ready;
  assign deliver   = out_valid & out_ready;

  // Next-state and operand-accept decode.
  always_comb begin
    state_next = state;
    ready_raw  = 1'b0;
    unique case (state)
      IDLE: begin
        ready_raw = 1'b1;
        if (in_valid) state_next = BUSY;
      end
      BUSY: begin
        if (last_step) state_next = DONE;
      end
      DONE: begin
        if (out_ready) begin
          ready_raw  = 1'b1;
          state_next = in_valid ? BUSY : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register plus operand capture, Horner iteration and result latch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      acc_p0    <= '0;
      base_p0   <= '0;
      last_prod <= '0;
      out_prod  <= '0;
    end else begin
      state <= state_next;
      if (deliver) last_prod <= out_prod;
      if (accept) begin
        a_p0    <= in_a;
        b_p0    <= in_b;
        acc_p0  <= '0;
        cnt     <= '0;
        // A same-edge delivery supplies the product being handed over now.
        base_p0 <= in_acc ? (deliver ? out_prod : last_prod) : '0;
      end else if (state == BUSY) begin
        acc_p0 <= acc_step;
        b_p0   <= b_p0 << DIGIT;
        cnt    <= cnt + 1'b1;
        if (last_step) out_prod <= acc_step ^ base_p0;
      end
    end
  end

endmodule

// File: doc/gf_mul_seq.md
GF_MUL_SEQ -- requirements
Module: gf_mul_seq

Interface
REQ-001 The module SHALL have parameter M, default 8, meaning the field degree; legal range 2..16.
REQ-002 The module SHALL have parameter POLY, default 9'h11D (M+1 bits), meaning the field polynomial; bit M and bit 0 SHALL be 1.
REQ-003 The module SHALL have parameter DIGIT, default 1, meaning the multiplier bits consumed per cycle; M mod DIGIT SHALL be 0, and illegal values SHALL stop elaboration.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The module SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 The module SHALL have port in_valid, input, 1 bit: operand request.
REQ-007 The module SHALL have port in_ready, output, 1 bit: operand accept.
REQ-008 The module SHALL have port in_a, input, M bits: multiplicand, polynomial basis.
REQ-009 The module SHALL have port in_b, input, M bits: multiplier, polynomial basis.
REQ-010 The module SHALL have port in_acc, input, 1 bit: when 1, the result is in_a*in_b XOR the previously delivered product.
REQ-011 The module SHALL have port out_valid, output, 1 bit: result valid.
REQ-012 The module SHALL have port out_ready, input, 1 bit: downstream accept.
REQ-013 The module SHALL have port out_prod, output, M bits: result, polynomial basis.
REQ-014 The module SHALL have port busy, output, 1 bit: high in BUSY state.

Function
REQ-015 The module SHALL compute the product in GF(2^M) as the product of in_a and in_b reduced modulo POLY, MSB-first (Horner): per step, acc = (acc·x mod POLY) XOR (b_bit ? a : 0).
REQ-016 The module SHALL perform DIGIT Horner steps per cycle, taking in_b bits from the MSB downward, so BUSY lasts exactly L = M/DIGIT cycles.
REQ-017 The module SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-018 IDLE SHALL transition to BUSY on in_valid && in_ready; in_a, in_b and in_acc SHALL be registered on that edge, and the working accumulator SHALL be cleared.
REQ-019 BUSY SHALL transition to DONE after its L-th cycle; out_valid SHALL rise on the edge that ends the last step.
REQ-020 Handshake latency SHALL be L+1 cycles from the accepting edge to the first cycle with out_valid=1 (9 cycles for M=8, DIGIT=1; 3 cycles for M=8, DIGIT=4).
REQ-021 DONE SHALL hold out_valid=1 and keep out_prod stable until out_valid && out_ready.
REQ-022 On out_valid && out_ready, the FSM SHALL go to IDLE, or directly to BUSY if in_valid is also high in that cycle (back-to-back, no bubble).
REQ-023 in_ready SHALL equal (state==IDLE) || (state==DONE && out_ready); it SHALL be 0 throughout BUSY.
REQ-024 Inputs presented while in_ready=0 SHALL be ignored and SHALL NOT corrupt the operation in flight.
REQ-025 The module SHALL hold a last-product register, loaded with out_prod on each out_valid && out_ready handshake.
REQ-026 When the registered in_acc is 1, the module SHALL form out_prod = product XOR last-product, using the last-product value at the accept edge.
REQ-027 If a back-to-back accept coincides with delivery, the last-product value used SHALL be the product being delivered in that same cycle.
REQ-028 out_prod SHALL be a registered output; its value outside DONE is don't-care for checking but SHALL NOT be X after reset.
REQ-029 in_b=0 or in_a=0 SHALL yield 0, in_b=1 SHALL yield in_a, and both SHALL take the full L cycles with no early termination.
REQ-030 All arithmetic SHALL be carry-free XOR, and the intermediate acc SHALL never exceed M bits (reduction applied on each shift).

Reset
REQ-031 When rst_n=0 at a clock edge, the FSM SHALL go to IDLE and out_valid, busy, out_prod, the last-product register and the working accumulator SHALL all become 0.
REQ-032 During reset, in_ready SHALL be 0; it SHALL become 1 in the first cycle after rst_n returns to 1.
REQ-033 Reset asserted mid-BUSY or in DONE SHALL abort the operation: no out_valid SHALL be produced for it, and the aborted result SHALL NOT be loaded into the last-product register.

Verification
REQ-034 Basic product (M=8, POLY=11D, DIGIT=1): in_a=80, in_b=80, in_acc=0 -> out_valid 9 cycles after accept with out_prod=13; in_a=03, in_b=03 -> 05; in_a=02, in_b=80 -> 1D.
REQ-035 Identity and zero: in_a=A7, in_b=01 -> A7; in_a=A7, in_b=00 -> 00; both with latency 9.
REQ-036 Accumulate: 80*80 (in_acc=0) delivered = 13, then 03*03 with in_acc=1 -> 16; both issued back-to-back with out_ready=1, showing no idle cycle between the DONE and BUSY states.
REQ-037 Backpressure: out_ready held 0 for 5 cycles in DONE -> out_prod stable, in_ready=0, new in_valid ignored; out_ready=1 -> single handshake.
REQ-038 Reset mid-operation: rst_n=0 in BUSY cycle 4 -> next cycle out_valid=0, busy=0, out_prod=00; a subsequent 80*80 with in_acc=1 -> 13 (last-product register was cleared).
REQ-039 DIGIT=4 and DIGIT=8 builds: the same vectors SHALL give identical results with latencies 3 and 2, and a random 10k-vector comparison against a reference model SHALL show zero mismatches.
